i2c_target_ctrl: RTL
====================

// Module: i2c_target_ctrl
// PURPOSE
//  I2C target (slave) controller: the responder end of the I2C bus driven by our master/BFM.
//  Oversamples scl_in/sda_in on the system clock and detects START, repeated START and STOP.
//  Matches a 7-bit address, ACKs it, then streams bytes to or from a local byte-wide handshake.
//  Drives the bus open-drain through the external buffer pins (scl_out/sda_out/scl_oe/sda_oe).
// PARAMETERS
//  TARGET_ADDR  7'h50  7-bit address this target responds to
//  FILT_CYCLES  3      consecutive equal samples required before a synced scl/sda change is accepted
// PORTS
//  clk          in   1  system clock (>= 20x SCL frequency)
//  rst_n        in   1  asynchronous active-low reset
//  scl_in       in   1  SCL from I/O buffer (async)
//  sda_in       in   1  SDA from I/O buffer (async)
//  scl_out      out  1  constant 0 (open-drain low level)
//  scl_oe       out  1  1 = pull SCL low (clock stretch)
//  sda_out      out  1  constant 0 (open-drain low level)
//  sda_oe       out  1  1 = pull SDA low
//  wr_valid     out  1  1-clk pulse: wr_data holds a byte received from the master
//  wr_data      out  8  received byte, stable until the next wr_valid
//  rd_req       out  1  request for the next byte to transmit to the master
//  rd_ack       in   1  rd_data valid (used only with I2C_CLK_STRETCH_EN)
//  rd_data      in   8  byte to transmit, MSB first
//  start_det    out  1  1-clk pulse on START or repeated START
//  stop_det     out  1  1-clk pulse on STOP
//  busy         out  1  1 from START to STOP
// BEHAVIOUR
//  Reset: all outputs 0, bus released, FSM=IDLE, bit counter=0. Reset mid-transfer releases SDA/SCL at once.
//  Input path: 2-flop sync, then FILT_CYCLES stable filter; edge detect runs on the filtered copies.
//  START = filtered SDA fall while SCL high; STOP = SDA rise while SCL high. Both override any state.
//  START/Sr from any state -> ADDR with bit counter cleared, sda_oe dropped. STOP -> IDLE, busy=0.
//  Sampling: SDA is sampled on the filtered SCL rising edge. SDA is changed only on the filtered SCL falling edge.
//  States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
//  ADDR: shift 8 bits (7 addr + R/W). On the 8th SCL fall: on match, sda_oe=1 -> ADDR_ACK; otherwise IGNORE.
//  IGNORE: no bus drive; exit only on START/Sr or STOP.
//  ADDR_ACK: on the following SCL fall, R/W=0 -> WR_DATA (release SDA); R/W=1 -> RD_DATA (drive bit7).
//  WR_DATA: shift 8 bits. wr_data/wr_valid are updated 1 clk after the 8th SCL rise.
//    On the 8th SCL fall, sda_oe=1 (ACK every byte) -> WR_ACK.
//  WR_ACK: on SCL fall, release SDA -> WR_DATA.
//  RD_DATA: sda_oe = ~shift[7]. Shift on each SCL fall. After the 8th bit's SCL fall, release SDA -> RD_ACK.
//  RD_ACK: sample the master's ACK on SCL rise. ACK (0): reload on the next SCL fall -> RD_DATA.
//    NACK (1): -> IGNORE until STOP/Sr.
//  rd_req: 1-clk pulse on the SCL fall ending ADDR_ACK (R/W=1), and on the SCL rise of an RD_ACK that carries ACK.
//  rd_data is registered into the TX shift register 1 clk after rd_req.
//  A NACKed final byte issues no rd_req. START coinciding with any edge wins over bit processing.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined:
//    rd_req is a level held until rd_ack=1; rd_data is captured on the clk where rd_ack=1.
//    If the SCL fall that must load the byte arrives before rd_ack, scl_oe=1 until 1 clk after rd_ack.
//    scl_oe is also dropped by START/STOP and reset.
//  I2C_CLK_STRETCH_EN undefined:
//    rd_ack is ignored, rd_req is a 1-clk pulse, rd_data is captured 1 clk later, scl_oe is tied 0.
// TESTING
//  1. Write 0x50/W, bytes 0xA5,0x3C, STOP -> ACK on addr+2 bytes; wr_valid x2 with 0xA5,0x3C; stop_det once.
//  2. Address 0x51/W -> no ACK (SDA high on 9th clk), no wr_valid, FSM IGNORE until STOP, busy 0 after STOP.
//  3. Read 0x50/R, rd_data=0x96 then 0x0F, master ACK then NACK -> SDA bits 10010110, 00001111; rd_req x2.
//  4. Write 0x50/W, 0x11, Sr, 0x50/R -> start_det x2, wr_valid 0x11, read phase starts with rd_req.
//  5. STRETCH_EN: read with rd_ack delayed 200 clk -> SCL held low ~200 clk, correct byte, no bit loss.
//  6. rst_n low during byte 2 of a read -> sda_oe/scl_oe 0 immediately; a new transfer after reset succeeds.

Source files
------------

// File: rtl/i2c_target_ctrl_if.sv
// I2C target bundle: open-drain pad pins, local byte handshake and bus status.
// slave modport: the target controller; master modport: pad ring / local logic / bench.
// Pad inputs are async to clk; the target synchronises them internally.
interface i2c_target_ctrl_if;
  logic       scl_in;
  logic       sda_in;
  logic       scl_out;
  logic       scl_oe;
  logic       sda_out;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, rd_ack, rd_data,
    output scl_out, scl_oe, sda_out, sda_oe, wr_valid, wr_data, rd_req,
           start_det, stop_det, busy
  );

  modport master (
    output scl_in, sda_in, rd_ack, rd_data,
    input  scl_out, scl_oe, sda_out, sda_oe, wr_valid, wr_data, rd_req,
           start_det, stop_det, busy
  );
endinterface

// File: rtl/i2c_target_ctrl.sv
// I2C target: 7-bit address match, byte write sink / byte read source, open-drain pad drive.
// Latency: pad -> event ~5 clk (2 sync + FILT_CYCLES filter); wr_valid 1 clk after 8th SCL rise.
// Backpressure: with I2C_CLK_STRETCH_EN, SCL is held low until rd_ack supplies the read byte;
//   without it rd_ack is ignored and rd_data must be valid 1 clk after the rd_req pulse.
// Ports: clk, rst_n (async active-low), bus (i2c_target_ctrl_if.slave: pads, wr_*/rd_*, status).
// Optional macro: I2C_CLK_STRETCH_EN.
module i2c_target_ctrl #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILT_CYCLES = 3
) (
  input logic             clk,
  input logic             rst_n,
  i2c_target_ctrl_if.slave bus
);

`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]    scl_sync, sda_sync;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_q, sda_q;

  // A synced level replaces the filtered one only after FILT_CYCLES equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == CW'(FILT_CYCLES - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + CW'(1);
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == CW'(FILT_CYCLES - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + CW'(1);
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_ev = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_ev  = scl_f & scl_q & ~sda_q & sda_f;

  // ---------------- protocol FSM ----------------
  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, wr_data_q;
  logic       rw, tx_vld, wr_pend, rel_pend;
  logic       sda_oe_q, scl_oe_q, wr_valid_q, rd_req_q, start_q, stop_q, busy_q;

  // cap: the clk where rd_data is taken. avail/next_byte let an RD_ACK fall that
  // coincides with the capture use rd_data directly instead of stretching.
  logic       cap, avail;
  logic [7:0] next_byte;
  assign cap       = rd_req_q & (bus.rd_ack | ~STRETCH_EN);
  assign avail     = tx_vld | cap;
  assign next_byte = tx_vld ? tx_sr : bus.rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      wr_data_q  <= '0;
      rw         <= 1'b0;
      tx_vld     <= 1'b0;
      wr_pend    <= 1'b0;
      rel_pend   <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      wr_pend    <= 1'b0;
      rel_pend   <= 1'b0;

      if (cap) begin
        rd_req_q <= 1'b0;
        rel_pend <= 1'b1;
        tx_sr    <= bus.rd_data;
        // Already in RD_DATA means the bit-7 fall has passed: drive now.
        if (state == RD_DATA) sda_oe_q <= ~bus.rd_data[7];
        else                  tx_vld   <= 1'b1;
      end
      // SCL is let go one clk after the byte lands so SDA leads the rising edge.
      if (rel_pend) scl_oe_q <= 1'b0;
      if (wr_pend) begin
        wr_data_q  <= rx_sr;
        wr_valid_q <= 1'b1;
      end

      if (start_ev || stop_ev) begin
        state    <= start_ev ? ADDR : IDLE;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
        scl_oe_q <= 1'b0;
        rd_req_q <= 1'b0;
        tx_vld   <= 1'b0;
        busy_q   <= start_ev;
        start_q  <= start_ev;
        stop_q   <= stop_ev;
      end else begin
        case (state)
          ADDR, WR_DATA: begin
            if (scl_rise) begin
              rx_sr   <= {rx_sr[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              if (state == WR_DATA && bit_cnt == 4'd7) wr_pend <= 1'b1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == WR_DATA) begin
                sda_oe_q <= 1'b1;
                state    <= WR_ACK;
              end else if (rx_sr[7:1] == TARGET_ADDR) begin
                rw       <= rx_sr[0];
                sda_oe_q <= 1'b1;
                state    <= ADDR_ACK;
              end else state <= IGNORE;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            sda_oe_q <= 1'b0;
            bit_cnt  <= '0;
            if (rw) begin
              // First read byte is requested here; SDA follows on capture.
              state    <= RD_DATA;
              rd_req_q <= 1'b1;
              if (STRETCH_EN) scl_oe_q <= 1'b1;
            end else state <= WR_DATA;
          end
          WR_ACK: if (scl_fall) begin
            sda_oe_q <= 1'b0;
            state    <= WR_DATA;
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= RD_ACK;
            end else begin
              tx_sr    <= {tx_sr[6:0], 1'b0};
              sda_oe_q <= ~tx_sr[6];
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) rd_req_q <= 1'b1;
              else        state    <= IGNORE;
            end else if (scl_fall) begin
              state   <= RD_DATA;
              bit_cnt <= '0;
              tx_vld  <= 1'b0;
              if (avail) begin
                tx_sr    <= next_byte;
                sda_oe_q <= ~next_byte[7];
              end else if (STRETCH_EN) scl_oe_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.scl_out   = 1'b0;
  assign bus.sda_out   = 1'b0;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.busy      = busy_q;

endmodule
